// File: rtl/datamover_pkg.sv
// Shared definitions for the DataMover memory responder: command field offsets,
// status bit positions, decoded-command struct, FSM state types and keep/status helpers.
package datamover_pkg;

    localparam int BTT_LSB   = 0;
    localparam int BTT_MSB   = 22;
    localparam int SADDR_LSB = 32;
    localparam int TAG_W     = 4;

    // The tag sits directly above the address field, so its offset depends on the address width.
    function automatic int tag_lsb(input int addr_w);
        return SADDR_LSB + addr_w;
    endfunction

    localparam int TAG_LSB = tag_lsb(40);

    localparam int STS_OKAY   = 7;
    localparam int STS_SLVERR = 6;
    localparam int STS_DECERR = 5;
    localparam int STS_INTERR = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      saddr;
        logic [22:0]      btt;
    } dm_cmd_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_STS} w_state_e;

`ifdef DM_MM2S_STS_EN
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STS} r_state_e;
`else
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
`endif

    function automatic logic [7:0] last_keep(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : ~(8'hFF << rem);
    endfunction

    function automatic logic [7:0] sts_byte(input logic decerr, input logic interr,
                                            input logic [TAG_W-1:0] tag);
        logic [7:0] s;
        s             = '0;
        s[STS_OKAY]   = ~(decerr | interr);
        s[STS_SLVERR] = 1'b0;
        s[STS_DECERR] = decerr;
        s[STS_INTERR] = interr;
        s[3:0]        = tag;
        return s;
    endfunction

endpackage

// File: rtl/dm_cmd_decode.sv
// Combinational DataMover command decoder: extracts tag/address/BTT and derives
// beat count, starting word index, last-beat keep mask and the zero/unaligned flag.
module dm_cmd_decode
    import datamover_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 40,
    parameter int MEM_AW         = 10
) (
    input  logic [40+DDR_ADDR_WIDTH-1:0] i_cmd,
    output dm_cmd_t                      o_cmd,
    output logic [20:0]                  o_beats,
    output logic [MEM_AW-1:0]            o_index,
    output logic                         o_bad,
    output logic [7:0]                   o_keep_last
);

    localparam int TAGL = tag_lsb(DDR_ADDR_WIDTH);

    logic [23:0] w_btt_rnd;
    logic        w_unused;

    always_comb begin
        o_cmd       = '0;
        o_cmd.btt   = i_cmd[BTT_MSB:BTT_LSB];
        o_cmd.saddr = 64'(i_cmd[SADDR_LSB +: DDR_ADDR_WIDTH]);
        o_cmd.tag   = i_cmd[TAGL +: TAG_W];
    end

    assign w_btt_rnd   = {1'b0, o_cmd.btt} + 24'd7;
    assign o_beats     = w_btt_rnd[23:3];
    assign o_index     = o_cmd.saddr[MEM_AW+2:3];
    assign o_bad       = (o_cmd.btt == '0) || (o_cmd.saddr[2:0] != 3'b000);
    assign o_keep_last = last_keep(o_cmd.btt[2:0]);

    // TYPE/DSA/EOF/DRR and reserved bits carry nothing this responder acts on.
    assign w_unused = ^{i_cmd[31:23], i_cmd[40+DDR_ADDR_WIDTH-1:TAGL+TAG_W]};

endmodule

// File: rtl/datamover_mem_responder.sv
// Behavioural DataMover + memory stand-in: S2MM writes into a word memory with a status beat,
// MM2S streams words back. Define DM_MM2S_STS_EN to add an MM2S status channel.
module datamover_mem_responder
    import datamover_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 40,
    parameter int MEM_AW         = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [40+DDR_ADDR_WIDTH-1:0] i_s2mm_cmd_tdata,
    input  logic                         i_s2mm_cmd_tvalid,
    output logic                         o_s2mm_cmd_tready,
    input  logic [63:0]                  i_s2mm_tdata,
    input  logic [7:0]                   i_s2mm_tkeep,
    input  logic                         i_s2mm_tvalid,
    input  logic                         i_s2mm_tlast,
    output logic                         o_s2mm_tready,
    output logic [7:0]                   o_s2mm_sts_tdata,
    output logic                         o_s2mm_sts_tkeep,
    output logic                         o_s2mm_sts_tvalid,
    output logic                         o_s2mm_sts_tlast,
    input  logic                         i_s2mm_sts_tready,
    input  logic [40+DDR_ADDR_WIDTH-1:0] i_mm2s_cmd_tdata,
    input  logic                         i_mm2s_cmd_tvalid,
    output logic                         o_mm2s_cmd_tready,
    output logic [63:0]                  o_mm2s_tdata,
    output logic [7:0]                   o_mm2s_tkeep,
    output logic                         o_mm2s_tvalid,
    output logic                         o_mm2s_tlast,
    input  logic                         i_mm2s_tready
`ifdef DM_MM2S_STS_EN
    ,
    output logic [7:0]                   o_mm2s_sts_tdata,
    output logic                         o_mm2s_sts_tkeep,
    output logic                         o_mm2s_sts_tvalid,
    output logic                         o_mm2s_sts_tlast,
    input  logic                         i_mm2s_sts_tready
`endif
);

    localparam int DEPTH = 1 << MEM_AW;

    logic [63:0] r_mem [0:DEPTH-1];

    dm_cmd_t           w_wcmd, w_rcmd;
    logic [20:0]       w_wbeats, w_rbeats;
    logic [MEM_AW-1:0] w_widx, w_ridx;
    logic              w_wbad, w_rbad;
    logic [7:0]        w_wkeep, w_rkeep;
    logic              w_unused;

    dm_cmd_decode #(.DDR_ADDR_WIDTH(DDR_ADDR_WIDTH), .MEM_AW(MEM_AW)) u_wdec (
        .i_cmd(i_s2mm_cmd_tdata), .o_cmd(w_wcmd), .o_beats(w_wbeats),
        .o_index(w_widx), .o_bad(w_wbad), .o_keep_last(w_wkeep)
    );

    dm_cmd_decode #(.DDR_ADDR_WIDTH(DDR_ADDR_WIDTH), .MEM_AW(MEM_AW)) u_rdec (
        .i_cmd(i_mm2s_cmd_tdata), .o_cmd(w_rcmd), .o_beats(w_rbeats),
        .o_index(w_ridx), .o_bad(w_rbad), .o_keep_last(w_rkeep)
    );

    // Holds command readies low through reset and for the first cycle after it.
    logic r_live;
    always_ff @(posedge clk) begin
        if (rst) r_live <= 1'b0;
        else     r_live <= 1'b1;
    end

    w_state_e          r_w_state, w_w_state_nx;
    logic [MEM_AW-1:0] r_w_idx;
    logic [20:0]       r_w_left;
    logic [TAG_W-1:0]  r_w_tag;
    logic              r_w_oor, r_w_decerr, r_w_interr;
    logic              w_wcmd_hs, w_wdat_hs, w_w_final;

    assign w_wcmd_hs = o_s2mm_cmd_tready & i_s2mm_cmd_tvalid;
    assign w_wdat_hs = o_s2mm_tready & i_s2mm_tvalid;
    assign w_w_final = (r_w_left == 21'd1);

    always_comb begin
        w_w_state_nx      = r_w_state;
        o_s2mm_cmd_tready = r_live && (r_w_state == W_IDLE);
        o_s2mm_tready     = (r_w_state == W_DATA);
        o_s2mm_sts_tvalid = (r_w_state == W_STS);
        o_s2mm_sts_tkeep  = o_s2mm_sts_tvalid;
        o_s2mm_sts_tlast  = o_s2mm_sts_tvalid;
        o_s2mm_sts_tdata  = o_s2mm_sts_tvalid ? sts_byte(r_w_decerr, r_w_interr, r_w_tag) : 8'h00;
        case (r_w_state)
            W_IDLE:  if (w_wcmd_hs) w_w_state_nx = w_wbad ? W_STS : W_DATA;
            W_DATA:  if (w_wdat_hs && w_w_final) w_w_state_nx = W_STS;
            W_STS:   if (i_s2mm_sts_tready) w_w_state_nx = W_IDLE;
            default: w_w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_w_state <= W_IDLE;
        else     r_w_state <= w_w_state_nx;
    end

    // Once the running index passes the top word, every later beat is a DECERR drop.
    always_ff @(posedge clk) begin
        if (w_wcmd_hs) begin
            r_w_tag    <= w_wcmd.tag;
            r_w_idx    <= w_widx;
            r_w_left   <= w_wbeats;
            r_w_oor    <= 1'b0;
            r_w_decerr <= 1'b0;
            r_w_interr <= w_wbad;
        end else if (w_wdat_hs) begin
            r_w_left <= r_w_left - 21'd1;
            r_w_idx  <= r_w_idx + MEM_AW'(1);
            if (&r_w_idx)                      r_w_oor    <= 1'b1;
            if (r_w_oor)                       r_w_decerr <= 1'b1;
            if (i_s2mm_tlast != w_w_final)     r_w_interr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wdat_hs && !r_w_oor) begin
            for (int b = 0; b < 8; b++) begin
                if (i_s2mm_tkeep[b]) r_mem[r_w_idx][b*8 +: 8] <= i_s2mm_tdata[b*8 +: 8];
            end
        end
    end

    r_state_e          r_r_state, w_r_state_nx;
    logic [MEM_AW-1:0] r_r_idx;
    logic [20:0]       r_r_left;
    logic [7:0]        r_r_keep;
    logic [63:0]       r_rdata;
    logic              r_r_oor;
    logic              w_rcmd_hs, w_rdat_hs, w_r_final;

    assign w_rcmd_hs = o_mm2s_cmd_tready & i_mm2s_cmd_tvalid;
    assign w_rdat_hs = o_mm2s_tvalid & i_mm2s_tready;
    assign w_r_final = (r_r_left == 21'd1);

    always_comb begin
        w_r_state_nx      = r_r_state;
        o_mm2s_cmd_tready = r_live && (r_r_state == R_IDLE);
        o_mm2s_tvalid     = (r_r_state == R_DATA);
        o_mm2s_tdata      = o_mm2s_tvalid ? r_rdata : 64'h0;
        o_mm2s_tlast      = o_mm2s_tvalid && w_r_final;
        o_mm2s_tkeep      = !o_mm2s_tvalid ? 8'h00 : (w_r_final ? r_r_keep : 8'hFF);
`ifdef DM_MM2S_STS_EN
        o_mm2s_sts_tvalid = (r_r_state == R_STS);
        o_mm2s_sts_tkeep  = o_mm2s_sts_tvalid;
        o_mm2s_sts_tlast  = o_mm2s_sts_tvalid;
        o_mm2s_sts_tdata  = o_mm2s_sts_tvalid ? sts_byte(r_r_decerr, r_r_interr, r_r_tag) : 8'h00;
`endif
        case (r_r_state)
`ifdef DM_MM2S_STS_EN
            R_IDLE:  if (w_rcmd_hs) w_r_state_nx = w_rbad ? R_STS : R_DATA;
            R_DATA:  if (w_rdat_hs && w_r_final) w_r_state_nx = R_STS;
            R_STS:   if (i_mm2s_sts_tready) w_r_state_nx = R_IDLE;
`else
            R_IDLE:  if (w_rcmd_hs && !w_rbad) w_r_state_nx = R_DATA;
            R_DATA:  if (w_rdat_hs && w_r_final) w_r_state_nx = R_IDLE;
`endif
            default: w_r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_r_state <= R_IDLE;
        else     r_r_state <= w_r_state_nx;
    end

    // The output register is loaded from the memory's pre-write content, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (w_rcmd_hs) begin
            r_rdata  <= r_mem[w_ridx];
            r_r_idx  <= w_ridx + MEM_AW'(1);
            r_r_oor  <= &w_ridx;
            r_r_left <= w_rbeats;
            r_r_keep <= w_rkeep;
        end else if (w_rdat_hs && !w_r_final) begin
            r_rdata  <= r_r_oor ? 64'h0 : r_mem[r_r_idx];
            r_r_idx  <= r_r_idx + MEM_AW'(1);
            r_r_left <= r_r_left - 21'd1;
            if (&r_r_idx) r_r_oor <= 1'b1;
        end
    end

`ifdef DM_MM2S_STS_EN
    logic [TAG_W-1:0] r_r_tag;
    logic             r_r_decerr, r_r_interr;

    always_ff @(posedge clk) begin
        if (w_rcmd_hs) begin
            r_r_tag    <= w_rcmd.tag;
            r_r_decerr <= 1'b0;
            r_r_interr <= w_rbad;
        end else if (w_rdat_hs && !w_r_final && r_r_oor) begin
            r_r_decerr <= 1'b1;
        end
    end
`endif

    assign w_unused = ^{w_wcmd.saddr, w_wcmd.btt, w_wkeep, w_rcmd.saddr, w_rcmd.btt
`ifndef DM_MM2S_STS_EN
                        , w_rcmd.tag
`endif
                        };

endmodule

// File: tb/tb_datamover_mem_responder.sv
// Scoreboard bench for datamover_mem_responder: directed S2MM/MM2S transactions push
// expected status bytes and read beats; a negedge monitor pops and compares them.
module tb_datamover_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [79:0] i_s2mm_cmd_tdata = '0;
    logic        i_s2mm_cmd_tvalid = 1'b0;
    logic        o_s2mm_cmd_tready;
    logic [63:0] i_s2mm_tdata = '0;
    logic [7:0]  i_s2mm_tkeep = '0;
    logic        i_s2mm_tvalid = 1'b0;
    logic        i_s2mm_tlast = 1'b0;
    logic        o_s2mm_tready;
    logic [7:0]  o_s2mm_sts_tdata;
    logic        o_s2mm_sts_tkeep, o_s2mm_sts_tvalid, o_s2mm_sts_tlast;
    logic        i_s2mm_sts_tready = 1'b1;
    logic [79:0] i_mm2s_cmd_tdata = '0;
    logic        i_mm2s_cmd_tvalid = 1'b0;
    logic        o_mm2s_cmd_tready;
    logic [63:0] o_mm2s_tdata;
    logic [7:0]  o_mm2s_tkeep;
    logic        o_mm2s_tvalid, o_mm2s_tlast;
    logic        i_mm2s_tready = 1'b1;
`ifdef DM_MM2S_STS_EN
    logic [7:0]  o_mm2s_sts_tdata;
    logic        o_mm2s_sts_tkeep, o_mm2s_sts_tvalid, o_mm2s_sts_tlast;
    logic        i_mm2s_sts_tready = 1'b1;
`endif

    always #5 clk = ~clk;

    datamover_mem_responder #(.DDR_ADDR_WIDTH(40), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .i_s2mm_cmd_tdata(i_s2mm_cmd_tdata), .i_s2mm_cmd_tvalid(i_s2mm_cmd_tvalid),
        .o_s2mm_cmd_tready(o_s2mm_cmd_tready),
        .i_s2mm_tdata(i_s2mm_tdata), .i_s2mm_tkeep(i_s2mm_tkeep), .i_s2mm_tvalid(i_s2mm_tvalid),
        .i_s2mm_tlast(i_s2mm_tlast), .o_s2mm_tready(o_s2mm_tready),
        .o_s2mm_sts_tdata(o_s2mm_sts_tdata), .o_s2mm_sts_tkeep(o_s2mm_sts_tkeep),
        .o_s2mm_sts_tvalid(o_s2mm_sts_tvalid), .o_s2mm_sts_tlast(o_s2mm_sts_tlast),
        .i_s2mm_sts_tready(i_s2mm_sts_tready),
        .i_mm2s_cmd_tdata(i_mm2s_cmd_tdata), .i_mm2s_cmd_tvalid(i_mm2s_cmd_tvalid),
        .o_mm2s_cmd_tready(o_mm2s_cmd_tready),
        .o_mm2s_tdata(o_mm2s_tdata), .o_mm2s_tkeep(o_mm2s_tkeep), .o_mm2s_tvalid(o_mm2s_tvalid),
        .o_mm2s_tlast(o_mm2s_tlast), .i_mm2s_tready(i_mm2s_tready)
`ifdef DM_MM2S_STS_EN
        ,
        .o_mm2s_sts_tdata(o_mm2s_sts_tdata), .o_mm2s_sts_tkeep(o_mm2s_sts_tkeep),
        .o_mm2s_sts_tvalid(o_mm2s_sts_tvalid), .o_mm2s_sts_tlast(o_mm2s_sts_tlast),
        .i_mm2s_sts_tready(i_mm2s_sts_tready)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  q_sts[$];
    logic [72:0] q_rd[$];
    logic [7:0]  m_sts;
    logic [72:0] m_rd;
    logic        m_stall = 1'b0;
    logic [63:0] m_held = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcmd(input logic [22:0] btt, input logic [39:0] sa, input logic [3:0] tag);
        int n = 0;
        i_s2mm_cmd_tdata  = {4'h0, tag, sa, 9'h0, btt};
        i_s2mm_cmd_tvalid = 1'b1;
        while (!o_s2mm_cmd_tready && n < 50) begin tick(); n++; end
        check("wcmd_accept", 64'(o_s2mm_cmd_tready), 64'd1);
        tick();
        i_s2mm_cmd_tvalid = 1'b0;
    endtask

    task automatic rcmd(input logic [22:0] btt, input logic [39:0] sa, input logic [3:0] tag);
        int n = 0;
        i_mm2s_cmd_tdata  = {4'h0, tag, sa, 9'h0, btt};
        i_mm2s_cmd_tvalid = 1'b1;
        while (!o_mm2s_cmd_tready && n < 50) begin tick(); n++; end
        check("rcmd_accept", 64'(o_mm2s_cmd_tready), 64'd1);
        tick();
        i_mm2s_cmd_tvalid = 1'b0;
        check("rd_first_latency", 64'(o_mm2s_tvalid), 64'd1);
    endtask

    task automatic wbeat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        i_s2mm_tdata  = d;
        i_s2mm_tkeep  = k;
        i_s2mm_tlast  = l;
        i_s2mm_tvalid = 1'b1;
        while (!o_s2mm_tready && n < 50) begin tick(); n++; end
        check("wbeat_accept", 64'(o_s2mm_tready), 64'd1);
        tick();
        i_s2mm_tvalid = 1'b0;
        i_s2mm_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_sts.size() + q_rd.size()) != 0 && n < 200) begin tick(); n++; end
        check("drain_pending", 64'(q_sts.size() + q_rd.size()), 64'd0);
    endtask

    task automatic check_idle_outs(input string nm);
        check(nm, {44'h0, o_s2mm_cmd_tready, o_mm2s_cmd_tready, o_s2mm_tready, o_s2mm_sts_tdata,
                   o_s2mm_sts_tkeep, o_s2mm_sts_tvalid, o_s2mm_sts_tlast,
                   o_mm2s_tkeep, o_mm2s_tvalid, o_mm2s_tlast}, 64'h0);
        check({nm, "_rdata"}, o_mm2s_tdata, 64'h0);
    endtask

    always @(negedge clk) begin
        if (o_s2mm_sts_tvalid && i_s2mm_sts_tready) begin
            if (q_sts.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sts_unexpected: got %h required no status", o_s2mm_sts_tdata);
            end else begin
                m_sts = q_sts.pop_front();
                check("sts_tdata", 64'(o_s2mm_sts_tdata), 64'(m_sts));
                check("sts_keep_last", {62'h0, o_s2mm_sts_tkeep, o_s2mm_sts_tlast}, 64'd3);
            end
        end
        if (o_mm2s_tvalid) begin
            if (m_stall) check("mm2s_hold", o_mm2s_tdata, m_held);
            if (!i_mm2s_tready) begin
                m_stall = 1'b1;
                m_held  = o_mm2s_tdata;
            end else begin
                m_stall = 1'b0;
                if (q_rd.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got %h required no beat", o_mm2s_tdata);
                end else begin
                    m_rd = q_rd.pop_front();
                    check("rd_tdata", o_mm2s_tdata, m_rd[72:9]);
                    check("rd_tkeep", 64'(o_mm2s_tkeep), 64'(m_rd[8:1]));
                    check("rd_tlast", 64'(o_mm2s_tlast), 64'(m_rd[0]));
                end
            end
        end else begin
            m_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  pat [4];
        pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;

        // reset values and cmd_tready release
        tick(); tick(); tick();
        check_idle_outs("reset_outs");
        rst = 1'b0;
        tick();
        check("cmd_ready_after_rst", {62'h0, o_s2mm_cmd_tready, o_mm2s_cmd_tready}, 64'd3);

        // 64-byte write at 0x1000 then read back
        q_sts.push_back(8'h8A);
        wcmd(23'd64, 40'h1000, 4'hA);
        check("wr_tready_latency", 64'(o_s2mm_tready), 64'd1);
        for (int i = 0; i < 8; i++) wbeat(64'h0123_4567_0000_0000 + 64'(i), 8'hFF, i == 7);
        check("sts_latency", 64'(o_s2mm_sts_tvalid), 64'd1);
        drain();
        for (int i = 0; i < 8; i++) q_rd.push_back({64'h0123_4567_0000_0000 + 64'(i), 8'hFF, i == 7});
        rcmd(23'd64, 40'h1000, 4'hA);
        drain();

        // prefill 3 words, partial overwrite with last keep 0F, stalled read-back
        q_sts.push_back(8'h81);
        wcmd(23'd24, 40'h0800, 4'h1);
        for (int i = 0; i < 3; i++) wbeat(64'hFFEE_DDCC_BBAA_9988, 8'hFF, i == 2);
        drain();
        q_sts.push_back(8'h82);
        wcmd(23'd20, 40'h0800, 4'h2);
        wbeat(64'h1000_0000_0000_0001, 8'hFF, 1'b0);
        wbeat(64'h2000_0000_0000_0002, 8'hFF, 1'b0);
        wbeat(64'h3333_3333_4444_4444, 8'h0F, 1'b1);
        drain();
        q_rd.push_back({64'h1000_0000_0000_0001, 8'hFF, 1'b0});
        q_rd.push_back({64'h2000_0000_0000_0002, 8'hFF, 1'b0});
        q_rd.push_back({64'hFFEE_DDCC_4444_4444, 8'h0F, 1'b1});
        rcmd(23'd20, 40'h0800, 4'h3);
        for (int k = 0; k < 4; k++) begin
            i_mm2s_tready = pat[k][0];
            tick();
        end
        i_mm2s_tready = 1'b1;
        drain();

        // early tlast, status held while sts_tready low
        i_s2mm_sts_tready = 1'b0;
        q_sts.push_back(8'h1A);
        wcmd(23'd32, 40'h0C00, 4'hA);
        wbeat(64'h11, 8'hFF, 1'b0);
        wbeat(64'h22, 8'hFF, 1'b1);
        wbeat(64'h33, 8'hFF, 1'b0);
        wbeat(64'h44, 8'hFF, 1'b0);
        check("early_last_sts_valid", 64'(o_s2mm_sts_tvalid), 64'd1);
        tick(); tick(); tick();
        check("sts_held_valid", 64'(o_s2mm_sts_tvalid), 64'd1);
        check("sts_held_data", 64'(o_s2mm_sts_tdata), 64'h1A);
        i_s2mm_sts_tready = 1'b1;
        drain();

        // unaligned address and zero BTT
        q_sts.push_back(8'h15);
        wcmd(23'd8, 40'h0003, 4'h5);
        check("unaligned_no_tready", 64'(o_s2mm_tready), 64'd0);
        check("unaligned_sts_valid", 64'(o_s2mm_sts_tvalid), 64'd1);
        drain();
        q_sts.push_back(8'h16);
        wcmd(23'd0, 40'h0100, 4'h6);
        check("zero_btt_no_tready", 64'(o_s2mm_tready), 64'd0);
        drain();

        // run off the top of memory
        q_sts.push_back(8'h27);
        wcmd(23'd16, 40'h1FF8, 4'h7);
        wbeat(64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0);
        wbeat(64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 1'b1);
        drain();
        q_rd.push_back({64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0});
        q_rd.push_back({64'h0, 8'hFF, 1'b1});
        rcmd(23'd16, 40'h1FF8, 4'h7);
        drain();

        // reset in the middle of a write
        wcmd(23'd32, 40'h0E00, 4'h9);
        wbeat(64'h55, 8'hFF, 1'b0);
        wbeat(64'h66, 8'hFF, 1'b0);
        check("midwrite_tready", 64'(o_s2mm_tready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outs("midrst_outs");
        tick();
        check("cmd_ready_after_midrst", {62'h0, o_s2mm_cmd_tready, o_mm2s_cmd_tready}, 64'd3);

        // short read with partial last beat
        d = 64'h0123_4567_0000_0001;
        q_rd.push_back({64'h0123_4567_0000_0000, 8'hFF, 1'b0});
        q_rd.push_back({d, 8'h0F, 1'b1});
        rcmd(23'd12, 40'h1000, 4'hB);
        drain();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datamover_mem_responder.md
# datamover_mem_responder

Behavioural responder for the AXI DataMover command/stream interface, sitting on the far side of the validation initiator's S2MM/MM2S ports. It accepts S2MM write commands and data into an internal word memory and returns an 8-bit status beat. It accepts MM2S read commands and streams the stored words back. It stands in for the DataMover IP plus DDR in block-level simulation and in on-chip loopback bring-up.

## Interface
Parameters:
- DDR_ADDR_WIDTH, 40, command address field width (A)
- MEM_AW, 10, log2 of memory depth in 64-bit words

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s2mm_cmd_tdata  in  40+A  write command
- s2mm_cmd_tvalid  in  1  write command valid
- s2mm_cmd_tready  out  1  write command accept
- s2mm_tdata  in  64  write data
- s2mm_tkeep  in  8  write byte enables
- s2mm_tvalid  in  1  write data valid
- s2mm_tlast  in  1  write data last
- s2mm_tready  out  1  write data ready
- s2mm_sts_tdata  out  8  write status
- s2mm_sts_tkeep  out  1  constant 1 when sts valid
- s2mm_sts_tvalid  out  1  status valid
- s2mm_sts_tlast  out  1  constant 1 when sts valid
- s2mm_sts_tready  in  1  status accept
- mm2s_cmd_tdata  in  40+A  read command
- mm2s_cmd_tvalid  in  1  read command valid
- mm2s_cmd_tready  out  1  read command accept
- mm2s_tdata  out  64  read data
- mm2s_tkeep  out  8  read byte valid
- mm2s_tvalid  out  1  read data valid
- mm2s_tlast  out  1  read data last
- mm2s_tready  in  1  read data ready

## Operation
- Command fields: BTT [22:0], TYPE [23], DSA [29:24], EOF [30], DRR [31], SADDR [31+A:32], TAG [35+A:32+A], RSVD above. TYPE/DSA/EOF/DRR/RSVD ignored.
- Beats = ceil(BTT/8); word index = SADDR[MEM_AW+2:3].
- Status byte: {OKAY[7], SLVERR[6], DECERR[5], INTERR[4], TAG[3:0]}; OKAY = no error bit set.
- Write FSM, states W_IDLE → W_DATA → W_STS → W_IDLE:
  - W_IDLE: cmd_tready=1. On handshake, latch tag/index/beat count. If BTT==0 or SADDR[2:0]!=0, go directly to W_STS with INTERR and no data consumed.
  - W_DATA: tready=1. Each handshake writes bytes enabled by tkeep to the current word, then index+1.
  - Beats whose index exceeds 2**MEM_AW-1 are not written and set DECERR; no wrap.
  - On the beat-count-th handshake, go to W_STS. If tlast is 0 on that beat, or 1 on any earlier beat, set INTERR. The transfer still runs to full beat count.
  - W_STS: sts_tvalid held with stable data until sts_tready, then W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: cmd_tready=1. On handshake, load the output register with the word at index and go to R_DATA.
  - BTT==0 or unaligned: command accepted, no data, stays R_IDLE (reported only with macro).
  - R_DATA: output register advances on tvalid&tready.
  - tlast on final beat. tkeep=8'hFF except final beat = low (BTT[2:0]) bytes set, or 8'hFF if BTT[2:0]==0.
  - Out-of-range index returns 64'h0 with DECERR recorded.
- The write and read FSMs are independent. Memory is dual-access: write port from S2MM, combinational read port to MM2S.
- Same-cycle write and read of one word: the read returns the old content.

## Timing
- Reset values: all tvalid/tready outputs 0, all tdata/tkeep/tlast 0, both FSMs in IDLE. Memory contents not reset.
- cmd_tready first asserts the cycle after rst deasserts.
- Write command accepted in cycle N → s2mm_tready=1 from N+1.
- Final data beat in cycle M → sts_tvalid in M+1.
- Read command accepted in cycle N → mm2s_tvalid with first word in N+1.
- Zero-stall read: one beat per cycle.
- rst mid-transfer: both FSMs return to IDLE next cycle. In-flight beats and status are dropped.

## Configuration
- DM_MM2S_STS_EN:
  - Defined: adds mm2s_sts_tdata[7:0], mm2s_sts_tvalid, mm2s_sts_tkeep, mm2s_sts_tlast and mm2s_sts_tready. The read FSM gains R_STS after R_DATA, or directly after an INTERR command, with the same status format and hold-until-ready rule.
  - Undefined: ports absent; read FSM is R_IDLE/R_DATA only.

## Structure
- Package datamover_pkg holds:
  - field offset localparams (BTT_LSB/MSB, SADDR_LSB, TAG_LSB) and status bit indices
  - a typedef struct packed for the decoded command {tag, saddr, btt}
  - a function computing the last-beat keep mask from BTT[2:0]
- One sub-module: dm_cmd_decode, a combinational field extractor plus beat-count/alignment/zero checks, instantiated once per direction.

## Test plan
- Write BTT=64, SADDR=0x1000, TAG=0xA, 8 beats 0..7, tlast on beat 8 → sts 8'h8A one cycle after the last beat. Read with the same command → words 0..7, tkeep 8'hFF throughout, tlast on beat 8.
- Write BTT=20 (3 beats, last tkeep 8'h0F) then read → final beat tkeep 8'h0F. Upper 4 bytes of that word keep their prior content.
- Write tlast on beat 2 of 4 → all 4 beats accepted, status 8'h1A (INTERR, tag A).
- Write SADDR=0x3 → no tready on data, status INTERR|tag. BTT=0 → the same.
- Write SADDR=0x1FF8, BTT=16 with MEM_AW=10 → beat 1 written, beat 2 dropped, status DECERR|tag.
- mm2s_tready toggled 1,0,0,1 during a read, plus rst asserted mid-write → read data held stable while stalled. After rst, all outputs are 0 and cmd_tready returns the next cycle.
